// File: rtl/corescore_reset_sequencer.sv
// Staggered reset release for CoreScore core groups: hold all groups in reset,
// then release them one by one in ascending order and flag completion.
module corescore_reset_sequencer #(
    parameter int NUM_GROUPS     = 4,
    parameter int HOLD_CYCLES    = 16,
    parameter int STAGGER_CYCLES = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_hold,
    output logic [NUM_GROUPS-1:0] o_rst_group,
    output logic                  o_done
);

    localparam int MAX_CYC = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam int IDX_W   = $clog2(NUM_GROUPS + 1);

    // The counter restarts at 0 on each release, so the terminal value is N-1.
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_GROUPS - 1);

    typedef enum logic [1:0] {
        ST_RESET,
        ST_HOLD,
        ST_RELEASE,
        ST_RUN
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [NUM_GROUPS-1:0] rst_group_q, rst_group_d;
    logic                  done_q, done_d;

    // NOTE: every next-state signal gets its hold value first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        rst_group_d = rst_group_q;
        done_d      = done_q;

        case (state_q)
            ST_RESET: begin
                state_d     = ST_HOLD;
                cnt_d       = '0;
                idx_d       = '0;
                rst_group_d = '1;
                done_d      = 1'b0;
            end

            ST_HOLD: begin
                if (!i_hold) begin
                    if (cnt_q == HOLD_LAST) begin
                        cnt_d       = '0;
                        // Groups release LSB first; shifting in zeros keeps released bits low.
                        rst_group_d = rst_group_q << 1;
                        idx_d       = IDX_W'(1);
                        if (NUM_GROUPS == 1) begin
                            done_d  = 1'b1;
                            state_d = ST_RUN;
                        end else begin
                            state_d = ST_RELEASE;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            ST_RELEASE: begin
                if (!i_hold) begin
                    if (cnt_q == STAGGER_LAST) begin
                        cnt_d       = '0;
                        rst_group_d = rst_group_q << 1;
                        idx_d       = idx_q + 1'b1;
                        if (idx_q == LAST_IDX) begin
                            done_d  = 1'b1;
                            state_d = ST_RUN;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            ST_RUN: begin
            end

            default: state_d = ST_RESET;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_RESET;
            cnt_q       <= '0;
            idx_q       <= '0;
            rst_group_q <= '1;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            rst_group_q <= rst_group_d;
            done_q      <= done_d;
        end
    end

    assign o_rst_group = rst_group_q;
    assign o_done      = done_q;

endmodule

// File: tb/tb_corescore_reset_sequencer.sv
// Randomized and directed bench for corescore_reset_sequencer against a
// release-schedule model counted in enabled edges since E0.
module tb_corescore_reset_sequencer;

    logic       clk;
    logic       rst;
    logic       hold;
    logic [3:0] grp4;
    logic       done4;
    logic [0:0] grp1;
    logic       done1;

    int n_tests;
    int n_fail;

    // Model state: in_reset until the first low-reset edge (E0), then en_cnt
    // counts enabled (hold low) edges since E0.
    bit in_reset;
    int en_cnt;

    corescore_reset_sequencer dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_hold      (hold),
        .o_rst_group (grp4),
        .o_done      (done4)
    );

    corescore_reset_sequencer #(
        .NUM_GROUPS     (1),
        .HOLD_CYCLES    (1),
        .STAGGER_CYCLES (1)
    ) dut1 (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_hold      (hold),
        .o_rst_group (grp1),
        .o_done      (done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int released(input int n, input int h, input int s);
        int r;
        if (in_reset || en_cnt < h) return 0;
        r = 1 + (en_cnt - h) / s;
        return (r > n) ? n : r;
    endfunction

    function automatic logic [63:0] exp_groups(input int n, input int h, input int s);
        logic [63:0] all_ones;
        logic [63:0] rel_mask;
        int          r;
        r        = released(n, h, s);
        all_ones = (64'd1 << n) - 64'd1;
        rel_mask = (64'd1 << r) - 64'd1;
        return all_ones & ~rel_mask;
    endfunction

    // One clock edge: drive on the falling edge, advance the model at the
    // rising edge, compare 1 ns later.
    task automatic step(input logic r, input logic h);
        @(negedge clk);
        rst  = r;
        hold = h;
        @(posedge clk);
        if (r) begin
            in_reset = 1'b1;
            en_cnt   = 0;
        end else if (in_reset) begin
            in_reset = 1'b0;
            en_cnt   = 0;
        end else if (!h && en_cnt < 1000000) begin
            en_cnt++;
        end
        #1;
        check("grp4", grp4, exp_groups(4, 16, 8));
        check("done4", done4, (released(4, 16, 8) == 4) ? 1 : 0);
        check("grp1", grp1, exp_groups(1, 1, 1));
        check("done1", done1, (released(1, 1, 1) == 1) ? 1 : 0);
    endtask

    task automatic do_reset(input int edges);
        for (int i = 0; i < edges; i++) step(1'b1, 1'b0);
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        in_reset = 1'b1;
        en_cnt   = 0;
        rst      = 1'b1;
        hold     = 1'b0;

        // Basic schedule: E0 then 45 free-running edges.
        do_reset(4);
        check("reset_grp", grp4, 4'hF);
        check("reset_done", done4, 1'b0);
        step(1'b0, 1'b0);                         // E0
        check("e0_dut1_grp", grp1, 1'b1);
        step(1'b0, 1'b0);                         // E0+1
        check("e1_dut1_done", done1, 1'b1);
        for (int i = 2; i <= 15; i++) step(1'b0, 1'b0);
        check("e15_grp", grp4, 4'hF);
        step(1'b0, 1'b0);                         // E0+16
        check("e16_grp", grp4, 4'hE);
        for (int i = 17; i <= 39; i++) step(1'b0, 1'b0);
        check("e39_done", done4, 1'b0);
        step(1'b0, 1'b0);                         // E0+40
        check("e40_grp", grp4, 4'h0);
        check("e40_done", done4, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0);

        // Hold high for 5 edges starting at E0+3.
        do_reset(2);
        step(1'b0, 1'b0);                         // E0
        for (int i = 1; i <= 2; i++) step(1'b0, 1'b0);
        for (int i = 3; i <= 7; i++) step(1'b0, 1'b1);
        for (int i = 8; i <= 20; i++) step(1'b0, 1'b0);
        check("hold_e20_grp", grp4, 4'hF);
        step(1'b0, 1'b0);                         // E0+21
        check("hold_e21_grp", grp4, 4'hE);
        for (int i = 22; i <= 45; i++) step(1'b0, 1'b0);
        check("hold_e45_done", done4, 1'b1);

        // Mid-sequence reset pulse at E0+30.
        do_reset(2);
        step(1'b0, 1'b0);                         // E0
        for (int i = 1; i <= 29; i++) step(1'b0, 1'b0);
        check("pulse_pre_grp", grp4, 4'hC);
        step(1'b1, 1'b0);                         // E0+30
        check("pulse_grp", grp4, 4'hF);
        check("pulse_done", done4, 1'b0);
        for (int i = 0; i < 45; i++) step(1'b0, 1'b0);

        // Reset and hold together at E0+20, hold kept high afterwards.
        do_reset(2);
        step(1'b0, 1'b0);
        for (int i = 1; i <= 19; i++) step(1'b0, 1'b0);
        step(1'b1, 1'b1);
        check("rsthold_grp", grp4, 4'hF);
        check("rsthold_done", done4, 1'b0);
        for (int i = 0; i < 30; i++) step(1'b0, 1'b1);
        check("rsthold_frozen", grp4, 4'hF);
        for (int i = 0; i < 45; i++) step(1'b0, 1'b0);

        // In RUN, hold toggles randomly and outputs must stay static.
        for (int i = 0; i < 100; i++) step(1'b0, 1'($urandom_range(0, 1)));
        check("run_grp", grp4, 4'h0);
        check("run_done", done4, 1'b1);

        // Fully random rst/hold traffic.
        do_reset(2);
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
